// File: rtl/imem_dmem_arbiter_if.sv
// imem_dmem_arbiter_if
//   Bundles every handshake and bus signal of the IF/LSU memory arbiter.
//   The arbiter connects through the slave modport. A testbench or the
//   surrounding pipeline drives the master side.
//
//   IF side  : i_if_valid, i_if_addr, i_if_flush -> o_if_ready, o_if_rdata
//   LSU side : i_lsu_valid, i_lsu_we, i_lsu_addr, i_lsu_wdata, i_lsu_bmask
//              -> o_lsu_ready, o_lsu_rdata
//   Mem bus  : o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask
//              <- i_mem_ack, i_mem_rdata
//   Debug    : o_owner (0=IF, 1=LSU), o_dbg_state (FSM state)
//
//   Handshake semantics (all three ports):
//     A requester raises valid and holds its fields stable. The arbiter
//     answers with a single-cycle ready pulse, and the read data is valid
//     in that same cycle. On the memory side o_mem_req is held with a
//     stable command until the cycle in which i_mem_ack is sampled high.
//     An IF request may also be withdrawn with i_if_flush instead of
//     waiting for ready.
interface imem_dmem_arbiter_if #(
    parameter int AW = 32
);
    logic          i_if_valid;
    logic [AW-1:0] i_if_addr;
    logic          i_if_flush;
    logic          o_if_ready;
    logic [31:0]   o_if_rdata;

    logic          i_lsu_valid;
    logic          i_lsu_we;
    logic [AW-1:0] i_lsu_addr;
    logic [31:0]   i_lsu_wdata;
    logic [3:0]    i_lsu_bmask;
    logic          o_lsu_ready;
    logic [31:0]   o_lsu_rdata;

    logic          o_mem_req;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [31:0]   o_mem_wdata;
    logic [3:0]    o_mem_bmask;
    logic          i_mem_ack;
    logic [31:0]   i_mem_rdata;

    logic          o_owner;
    logic [1:0]    o_dbg_state;

    modport slave (
        input  i_if_valid, i_if_addr, i_if_flush,
        output o_if_ready, o_if_rdata,
        input  i_lsu_valid, i_lsu_we, i_lsu_addr, i_lsu_wdata, i_lsu_bmask,
        output o_lsu_ready, o_lsu_rdata,
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask,
        input  i_mem_ack, i_mem_rdata,
        output o_owner, o_dbg_state
    );

    modport master (
        output i_if_valid, i_if_addr, i_if_flush,
        input  o_if_ready, o_if_rdata,
        output i_lsu_valid, i_lsu_we, i_lsu_addr, i_lsu_wdata, i_lsu_bmask,
        input  o_lsu_ready, o_lsu_rdata,
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask,
        output i_mem_ack, i_mem_rdata,
        input  o_owner, o_dbg_state
    );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter
//   Shares one 32-bit memory bus between instruction fetch (IF) and the
//   load/store unit (LSU). The LSU has fixed priority. IF wins once it has
//   watched STARVE_MAX LSU grants go by while it was waiting. A fetch that
//   is flushed while it is on the bus still runs to completion, so the bus
//   protocol is never violated, but its response is discarded.
//
//   Ports:
//     i_clk  - clock, rising edge
//     i_rst  - synchronous active-high reset
//     bus    - imem_dmem_arbiter_if.slave (IF, LSU, memory bus, debug)
//
//   FSM: IDLE (arbitrate) -> BUSY (o_mem_req held until ack) -> RESP
//   (one-cycle ready pulse) -> IDLE. With a zero-wait memory the best
//   throughput is one transaction every 3 cycles.
module imem_dmem_arbiter #(
    parameter int AW         = 32,
    parameter int STARVE_MAX = 4
) (
    input logic                 i_clk,
    input logic                 i_rst,
    imem_dmem_arbiter_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [1:0]    state_q, state_d;
    logic          owner_q, owner_d;     // 0 = IF, 1 = LSU
    logic          drop_q, drop_d;       // flushed fetch still on the bus
    logic [3:0]    starve_q, starve_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]    mem_bmask_q, mem_bmask_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   lsu_rdata_q, lsu_rdata_d;

    logic          if_cand;
    logic          if_forced;

    // A fetch that is being flushed in this cycle is not a candidate.
    assign if_cand   = bus.i_if_valid & ~bus.i_if_flush;
    assign if_forced = if_cand && (starve_q == STARVE_LIM);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        drop_d      = drop_q;
        starve_d    = starve_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_bmask_d = mem_bmask_q;
        if_rdata_d  = if_rdata_q;
        lsu_rdata_d = lsu_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (!bus.i_if_valid) begin
                    starve_d = 4'd0;
                end
                if (bus.i_lsu_valid && !if_forced) begin
                    owner_d     = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.i_lsu_we;
                    mem_addr_d  = bus.i_lsu_addr;
                    mem_wdata_d = bus.i_lsu_wdata;
                    mem_bmask_d = bus.i_lsu_bmask;
                    state_d     = S_BUSY;
                    // Only LSU grants taken while IF waits count towards
                    // starvation.
                    if (if_cand && (starve_q < STARVE_LIM)) begin
                        starve_d = starve_q + 4'd1;
                    end
                end else if (if_cand) begin
                    owner_d     = 1'b0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.i_if_addr;
                    mem_wdata_d = 32'h0;
                    mem_bmask_d = 4'hF;
                    state_d     = S_BUSY;
                    starve_d    = 4'd0;
                end
            end

            S_BUSY: begin
                if (!owner_q && bus.i_if_flush) begin
                    drop_d = 1'b1;
                end
                if (bus.i_mem_ack) begin
                    mem_req_d = 1'b0;
                    if (owner_q) begin
                        lsu_rdata_d = bus.i_mem_rdata;
                    end else begin
                        if_rdata_d = bus.i_mem_rdata;
                    end
                    // A flushed fetch skips RESP, so IF never sees a ready
                    // pulse for it.
                    if (!owner_q && (drop_q || bus.i_if_flush)) begin
                        state_d = S_IDLE;
                        drop_d  = 1'b0;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            drop_q      <= 1'b0;
            starve_q    <= 4'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
            mem_bmask_q <= 4'h0;
            if_rdata_q  <= 32'h0;
            lsu_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            drop_q      <= drop_d;
            starve_q    <= starve_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_bmask_q <= mem_bmask_d;
            if_rdata_q  <= if_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
        end
    end

    // A flush arriving in the RESP cycle itself still suppresses the IF
    // ready pulse, so the IF ready is gated combinationally with the flush.
    assign bus.o_if_ready  = (state_q == S_RESP) && !owner_q && !bus.i_if_flush;
    assign bus.o_lsu_ready = (state_q == S_RESP) && owner_q;
    assign bus.o_if_rdata  = if_rdata_q;
    assign bus.o_lsu_rdata = lsu_rdata_q;
    assign bus.o_mem_req   = mem_req_q;
    assign bus.o_mem_we    = mem_we_q;
    assign bus.o_mem_addr  = mem_addr_q;
    assign bus.o_mem_wdata = mem_wdata_q;
    assign bus.o_mem_bmask = mem_bmask_q;
    assign bus.o_owner     = owner_q;
    assign bus.o_dbg_state = state_q;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
module tb_imem_dmem_arbiter;

  localparam int STARVE_MAX = 4;
  localparam logic [1:0] ST_IDLE = 2'd0;

  logic clk;
  logic rst;
  int   cyc;

  imem_dmem_arbiter_if #(.AW(32)) bus ();

  imem_dmem_arbiter #(.AW(32), .STARVE_MAX(STARVE_MAX)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // ---------------- bookkeeping ----------------
  int checks;
  int failures;

  logic [31:0] if_exp_q[$];
  logic [32:0] lsu_exp_q[$];   // bit 32: compare read data (load)
  bit          grant_log[$];   // 1 = LSU, 0 = IF
  int          req_len_log[$];
  int          wait_q[$];
  int          if_rdy_cyc_log[$];
  int          last_lsu_rdy_cyc;
  int          last_if_rdy_cyc;

  logic [31:0] ref_mem[16];    // reference model of LSU data memory
  logic [31:0] bus_mem[16];    // memory behind the bus

  logic [31:0] cur_if_addr;
  logic        cur_lsu_we;
  logic [31:0] cur_lsu_addr;
  logic [31:0] cur_lsu_wdata;
  logic [3:0]  cur_lsu_bmask;
  bit          if_pending;
  int          if_issue_cyc;
  int          lsu_while_if;

  bit          resp_en;
  bit          in_txn;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input string msg);
    checks++;
    failures++;
    $display("FAIL %s: %s (t=%0t)", name, msg, $time);
  endtask

  function automatic logic [31:0] ifrom(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0F0F_1234;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] bm);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (bm[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [3:0] lsu_idx(input logic [31:0] a);
    logic [31:0] off;
    off = (a - 32'h100) >> 2;
    return off[3:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    bus.i_if_valid  = 1'b0;
    bus.i_if_flush  = 1'b0;
    bus.i_lsu_valid = 1'b0;
    bus.i_mem_ack   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    in_txn = 1'b0;
    if_pending = 1'b0;
  endtask

  task automatic lsu_op(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] bm, output int lat);
    int k;
    bit got;
    logic [3:0] idx;
    idx = lsu_idx(a);
    bus.i_lsu_valid = 1'b1;
    bus.i_lsu_we    = we;
    bus.i_lsu_addr  = a;
    bus.i_lsu_wdata = wd;
    bus.i_lsu_bmask = bm;
    cur_lsu_we = we; cur_lsu_addr = a; cur_lsu_wdata = wd; cur_lsu_bmask = bm;
    if (we) begin
      ref_mem[idx] = merge(ref_mem[idx], wd, bm);
      lsu_exp_q.push_back({1'b0, 32'h0});
    end else begin
      lsu_exp_q.push_back({1'b1, ref_mem[idx]});
    end
    k = 0;
    got = 1'b0;
    while (!got && k < 200) begin
      @(negedge clk);
      k++;
      if (bus.o_lsu_ready) got = 1'b1;
    end
    if (!got) fail("lsu_timeout", "no o_lsu_ready within 200 cycles");
    @(posedge clk);
    #1;
    bus.i_lsu_valid = 1'b0;
    lat = k - 1;
  endtask

  task automatic if_fetch(input logic [31:0] a, input int flush_at, output int lat);
    int k;
    bit got;
    bit flushed;
    logic [31:0] dummy;
    bus.i_if_valid = 1'b1;
    bus.i_if_addr  = a;
    cur_if_addr    = a;
    if_exp_q.push_back(ifrom(a));
    if_pending   = 1'b1;
    if_issue_cyc = cyc;
    lsu_while_if = 0;
    k = 0; got = 1'b0; flushed = 1'b0; lat = -1;
    while (!got && !flushed && k < 200) begin
      @(negedge clk);
      k++;
      if (bus.o_if_ready) got = 1'b1;
      @(posedge clk);
      #1;
      if (!got && k == flush_at) begin
        bus.i_if_flush = 1'b1;
        bus.i_if_valid = 1'b0;
        if_pending = 1'b0;
        if (if_exp_q.size() > 0) dummy = if_exp_q.pop_back();
        @(posedge clk);
        #1;
        bus.i_if_flush = 1'b0;
        flushed = 1'b1;
      end
    end
    if (got) begin
      bus.i_if_valid = 1'b0;
      lat = k - 1;
    end else if (!flushed) begin
      fail("if_timeout", "no o_if_ready within 200 cycles");
      bus.i_if_valid = 1'b0;
    end
  endtask

  // ---------------- memory responder ----------------
  initial begin : responder
    logic        t_owner, t_we;
    logic [31:0] t_addr, t_wdata;
    logic [3:0]  t_bmask;
    int          waits_left;
    int          req_len;
    bus.i_mem_ack   = 1'b0;
    bus.i_mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (resp_en && !rst) begin
        if (bus.o_mem_req) begin
          if (!in_txn) begin
            in_txn  = 1'b1;
            t_owner = bus.o_owner;
            t_we    = bus.o_mem_we;
            t_addr  = bus.o_mem_addr;
            t_wdata = bus.o_mem_wdata;
            t_bmask = bus.o_mem_bmask;
            req_len = 0;
            waits_left = (wait_q.size() > 0) ? wait_q.pop_front() : int'($urandom_range(0, 3));
            grant_log.push_back(t_owner);
            if (!t_owner) begin
              chk("if_cmd_addr", t_addr, cur_if_addr);
              chk("if_cmd_we", t_we, 1'b0);
              chk("if_cmd_bmask", t_bmask, 4'hF);
              if_pending = 1'b0;
            end else begin
              chk("lsu_cmd_addr", t_addr, cur_lsu_addr);
              chk("lsu_cmd_we", t_we, cur_lsu_we);
              chk("lsu_cmd_bmask", t_bmask, cur_lsu_bmask);
              if (t_we) chk("lsu_cmd_wdata", t_wdata, cur_lsu_wdata);
              // the grant was decided in cycle cyc-1; count it only if IF was visible then
              if (if_pending && if_issue_cyc < cyc) begin
                lsu_while_if++;
                chk("if_starve_bound", lsu_while_if <= STARVE_MAX, 1'b1);
              end
            end
          end else begin
            chk("cmd_stable", {bus.o_owner, bus.o_mem_we, bus.o_mem_bmask, bus.o_mem_addr},
                {t_owner, t_we, t_bmask, t_addr});
          end
          req_len++;
          if (waits_left == 0) begin
            bus.i_mem_ack = 1'b1;
            if (t_owner) begin
              bus.i_mem_rdata = bus_mem[lsu_idx(t_addr)];
              if (t_we) bus_mem[lsu_idx(t_addr)] = merge(bus_mem[lsu_idx(t_addr)], t_wdata, t_bmask);
            end else begin
              bus.i_mem_rdata = ifrom(t_addr);
            end
            in_txn = 1'b0;
            req_len_log.push_back(req_len);
          end else begin
            bus.i_mem_ack   = 1'b0;
            bus.i_mem_rdata = $urandom();
            waits_left--;
          end
        end else begin
          bus.i_mem_ack = 1'b0;
          if (in_txn) fail("req_dropped", "o_mem_req fell before ack");
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    logic [31:0] e_if;
    logic [32:0] e_lsu;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.o_if_ready || bus.o_lsu_ready)
          chk("ready_exclusive", bus.o_if_ready & bus.o_lsu_ready, 1'b0);
        if (bus.o_if_ready) begin
          last_if_rdy_cyc = cyc;
          if_rdy_cyc_log.push_back(cyc);
          if (if_exp_q.size() == 0) begin
            fail("if_ready_unexpected", "o_if_ready=1 with no fetch outstanding");
          end else begin
            e_if = if_exp_q.pop_front();
            chk("if_rdata", bus.o_if_rdata, e_if);
          end
        end
        if (bus.o_lsu_ready) begin
          last_lsu_rdy_cyc = cyc;
          if (lsu_exp_q.size() == 0) begin
            fail("lsu_ready_unexpected", "o_lsu_ready=1 with no access outstanding");
          end else begin
            e_lsu = lsu_exp_q.pop_front();
            if (e_lsu[32]) chk("lsu_rdata", bus.o_lsu_rdata, e_lsu[31:0]);
          end
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : main
    int lat;
    int l1;
    int l2;
    bit exp_order[7];
    logic [31:0] v;
    checks = 0; failures = 0;
    resp_en = 1'b1; in_txn = 1'b0;
    rst = 1'b1;
    bus.i_if_valid = 0; bus.i_if_addr = 0; bus.i_if_flush = 0;
    bus.i_lsu_valid = 0; bus.i_lsu_we = 0; bus.i_lsu_addr = 0;
    bus.i_lsu_wdata = 0; bus.i_lsu_bmask = 0;
    for (int i = 0; i < 16; i++) begin
      v = $urandom();
      ref_mem[i] = v;
      bus_mem[i] = v;
    end

    // reset state
    do_reset();
    @(negedge clk);
    chk("rst_mem_req", bus.o_mem_req, 1'b0);
    chk("rst_if_ready", bus.o_if_ready, 1'b0);
    chk("rst_lsu_ready", bus.o_lsu_ready, 1'b0);
    chk("rst_if_rdata", bus.o_if_rdata, 32'h0);
    chk("rst_lsu_rdata", bus.o_lsu_rdata, 32'h0);
    chk("rst_mem_cmd", {bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_bmask}, 64'h0);
    chk("rst_owner", bus.o_owner, 1'b0);
    chk("rst_state", bus.o_dbg_state, ST_IDLE);
    @(posedge clk); #1;

    // 1: single LSU load, zero-wait
    ref_mem[0] = 32'hDEADBEEF; bus_mem[0] = 32'hDEADBEEF;
    req_len_log.delete(); wait_q.delete(); wait_q.push_back(0);
    lsu_op(1'b0, 32'h100, 32'h0, 4'h0, lat);
    chk("t1_latency", lat, 2);
    chk("t1_req_cycles", req_len_log.size() == 1 ? req_len_log[0] : -1, 1);

    // 2: simultaneous IF + LSU store with 2 wait cycles
    do_reset();
    grant_log.delete(); req_len_log.delete(); wait_q.delete();
    wait_q.push_back(2); wait_q.push_back(0);
    fork
      lsu_op(1'b1, 32'h104, 32'h12345678, 4'b0011, l1);
      if_fetch(32'h200, -1, l2);
    join
    chk("t2_grants", grant_log.size() == 2 ? {grant_log[0], grant_log[1]} : 2'b00, 2'b10);
    chk("t2_store_req_cycles", req_len_log.size() >= 1 ? req_len_log[0] : -1, 3);
    chk("t2_if_after_lsu", last_if_rdy_cyc - last_lsu_rdy_cyc, 3);
    lsu_op(1'b0, 32'h104, 32'h0, 4'h0, lat);

    // 3: starvation bound, IF held while LSU streams 6 loads
    do_reset();
    grant_log.delete();
    exp_order = '{1, 1, 1, 1, 0, 1, 1};
    fork
      begin
        int li;
        if_fetch(32'h300, -1, li);
      end
      begin
        for (int i = 0; i < 6; i++) begin
          int ll;
          lsu_op(1'b0, 32'h100 + 32'(4 * i), 32'h0, 4'h0, ll);
        end
      end
    join
    chk("t3_grant_count", grant_log.size(), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < grant_log.size()) chk("t3_grant_order", grant_log[i], exp_order[i]);
    end

    // 4: flush while the fetch is on the bus
    do_reset();
    grant_log.delete(); req_len_log.delete(); wait_q.delete();
    wait_q.push_back(4);
    if_fetch(32'h200, 2, lat);
    repeat (8) @(posedge clk);
    #1;
    chk("t4_bus_completed", req_len_log.size() == 1 ? req_len_log[0] : -1, 5);
    chk("t4_state_idle", bus.o_dbg_state, ST_IDLE);
    wait_q.push_back(0);
    if_fetch(32'h300, -1, lat);
    chk("t4_next_fetch_latency", lat, 2);

    // 5: reset in the middle of a bus transaction, then a stray ack
    do_reset();
    resp_en = 1'b0;
    bus.i_mem_ack = 1'b0;
    bus.i_lsu_valid = 1'b1; bus.i_lsu_we = 1'b0; bus.i_lsu_addr = 32'h108;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_req_before_rst", bus.o_mem_req, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.i_lsu_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_req_after_rst", bus.o_mem_req, 1'b0);
    chk("t5_ready_after_rst", {bus.o_if_ready, bus.o_lsu_ready}, 2'b00);
    chk("t5_state_after_rst", bus.o_dbg_state, ST_IDLE);
    bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 32'hBAD0BAD0;
    @(posedge clk); #1;
    bus.i_mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_late_ack_ignored", {bus.o_mem_req, bus.o_if_ready, bus.o_lsu_ready, bus.o_dbg_state},
          {3'b000, ST_IDLE});
    end
    @(posedge clk); #1;
    in_txn = 1'b0;
    resp_en = 1'b1;

    // 6: back-to-back fetches on a zero-wait memory
    do_reset();
    wait_q.delete(); if_rdy_cyc_log.delete();
    for (int i = 0; i < 5; i++) wait_q.push_back(0);
    for (int i = 0; i < 5; i++) if_fetch(32'h400 + 32'(4 * i), -1, lat);
    chk("t6_ready_count", if_rdy_cyc_log.size(), 5);
    for (int i = 1; i < if_rdy_cyc_log.size(); i++)
      chk("t6_ready_spacing", if_rdy_cyc_log[i] - if_rdy_cyc_log[i-1], 3);

    // 7: random mix of loads, stores, fetches and flushes
    do_reset();
    wait_q.delete();
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          int ll;
          lsu_op(1'($urandom_range(0, 1)), 32'h100 + 32'(4 * $urandom_range(0, 15)),
                 $urandom(), 4'($urandom_range(1, 15)), ll);
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
      end
      begin
        for (int i = 0; i < 60; i++) begin
          int li;
          int fa;
          fa = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 6)) : -1;
          if_fetch(32'h200 + 32'(4 * $urandom_range(0, 255)), fa, li);
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
      end
    join
    repeat (10) @(posedge clk);
    #1;
    chk("rand_if_queue_empty", if_exp_q.size(), 0);
    chk("rand_lsu_queue_empty", lsu_exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares a single 32-bit memory bus port between two requesters: the IF-stage instruction fetch and the MEM-stage LSU.
- Each requester uses a VALID/READY transaction handshake. The LSU side drives the lsu_VALID/lsu_READY pair consumed by the pipeline hazard controller; IF stalls on fetch-not-ready.
- LSU has fixed priority, with bounded IF starvation.
- Supports killing an in-flight fetch on branch flush without corrupting the bus transaction.

Parameters:
- AW, 32, address width of all ports.
- STARVE_MAX, 4, consecutive LSU grants taken while IF waits before IF is forced to win (range 1..15).

Ports:
- i_clk  in  1  clock, all state updates on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_if_valid  in  1  fetch request; held high until o_if_ready or i_if_flush
- i_if_addr  in  AW  fetch address, stable while i_if_valid
- i_if_flush  in  1  kills the current or pending fetch (pred wrong / jal / jalr redirect)
- o_if_ready  out  1  one-cycle pulse: fetch complete, o_if_rdata valid this cycle
- o_if_rdata  out  32  fetched instruction, registered
- i_lsu_valid  in  1  LSU request; held with stable fields until o_lsu_ready
- i_lsu_we  in  1  1=store, 0=load
- i_lsu_addr  in  AW  load/store address
- i_lsu_wdata  in  32  store data
- i_lsu_bmask  in  4  byte enables for store
- o_lsu_ready  out  1  one-cycle pulse: access complete, o_lsu_rdata valid this cycle
- o_lsu_rdata  out  32  load data, registered (undefined content for stores)
- o_mem_req  out  1  bus request, held until i_mem_ack
- o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask  out  1/AW/32/4  registered bus command, stable while o_mem_req
- i_mem_ack  in  1  bus completes the transaction this cycle (variable latency, >=0 wait cycles)
- i_mem_rdata  in  32  read data, valid with i_mem_ack
- o_owner  out  1  0=IF, 1=LSU, current or last bus owner (debug/perf)

Behaviour:
- States: IDLE, BUSY, RESP. Owner register (0=IF, 1=LSU); drop flag.
- Reset (synchronous): state=IDLE, owner=0, drop=0, starve_cnt=0; o_mem_req=0, o_if_ready=0, o_lsu_ready=0, o_if_rdata=0, o_lsu_rdata=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_mem_bmask=0.
- Reset mid-transaction abandons it: o_mem_req is low the cycle after the reset edge. The bus must tolerate a dropped request.
- IDLE arbitration. Candidates are IF = i_if_valid & ~i_if_flush, and LSU = i_lsu_valid.
  - Only LSU: grant LSU. Only IF: grant IF.
  - Both: grant LSU unless starve_cnt==STARVE_MAX, then grant IF.
  - On grant, latch the command into the o_mem_* registers and go to BUSY; o_mem_req=1 from the next cycle.
- starve_cnt:
  - +1 on each LSU grant while i_if_valid & ~i_if_flush; saturates at STARVE_MAX.
  - Cleared on each IF grant, and when i_if_valid=0 in IDLE.
  - IF commands use we=0 and bmask=4'hF.
- BUSY:
  - o_mem_req=1 and command stable until the cycle i_mem_ack=1.
  - On ack: capture i_mem_rdata into the owner's rdata register; o_mem_req=0 next cycle.
  - Next state is RESP, except owner=IF with drop set (or i_if_flush this cycle), which goes to IDLE with drop cleared.
- Flush rules:
  - i_if_flush while owner=IF in BUSY sets drop. The bus transaction still completes; no o_if_ready is issued.
  - i_if_flush in RESP with owner=IF suppresses o_if_ready.
  - i_if_flush never affects LSU transactions.
- RESP:
  - Exactly one cycle with the owner's ready=1; then IDLE.
  - No grant occurs in RESP, so a requester's still-high valid is not re-granted.
- Latency: valid at cycle 0, ack in the first BUSY cycle (cycle 1), ready at cycle 2. Each wait cycle adds one. Peak throughput is 1 transaction per 3 cycles.
- Invariants:
  - o_if_ready and o_lsu_ready are never high together.
  - At most one bus transaction is outstanding.
  - i_mem_ack outside BUSY is ignored.

Test Plan:
- LSU load alone, addr 0x100, ack in first BUSY cycle, rdata 0xDEADBEEF -> o_mem_req high cycle 1 only; o_lsu_ready=1 and o_lsu_rdata=0xDEADBEEF at cycle 2; o_mem_we=0.
- IF and LSU valid together, LSU store wdata 0x12345678 bmask 4'b0011, 2 wait cycles -> LSU granted first; bus holds we=1/bmask=3 for 3 cycles; then IF granted; o_if_ready follows o_lsu_ready by exactly 3 cycles.
- STARVE_MAX=4, IF held valid, LSU issues 6 back-to-back loads -> grant order L,L,L,L,IF,L,L; starve_cnt returns to 0 after the IF grant.
- IF fetch 0x200 in BUSY, i_if_flush pulsed one cycle, ack 3 cycles later -> bus transaction completes; o_if_ready never asserted; next IF request to 0x300 granted from IDLE normally.
- i_rst asserted in BUSY with o_mem_req=1 -> next cycle o_mem_req=0, both ready=0, state IDLE; a late i_mem_ack is ignored.
- Back-to-back IF with 0-wait memory -> o_if_ready pulses every 3 cycles and is never high in consecutive cycles.
